seq_div25x9: RTL and testbench
==============================

Name: seq_div25x9

Overview:
Sequential restoring divider: the inverse of the team's 16x9 shift-add multiplier.
- Divides a 25-bit dividend by a 9-bit divisor, one quotient bit per clock.
- Produces a 16-bit quotient and a 9-bit remainder.
- Takes the multiplier's product plus the original 9-bit operand and recovers the 16-bit operand; used for round-trip checking and scaling paths.
- Controlled by an internal FSM with a START/BUSY/DONE handshake.

Parameters:
DVD_W, 25, dividend width
DVS_W, 9, divisor width
QUO_W, 16, quotient width; must equal DVD_W-DVS_W

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  synchronous, active-low reset
START  input  1  request; sampled only in IDLE
in_Dvd  input  25  dividend
in_Dvs  input  9  divisor
Quot  output  16  quotient
Rem  output  9  remainder
BUSY  output  1  high whenever state != IDLE
DONE  output  1  one-cycle completion pulse
OVF  output  1  quotient overflow flag, valid with DONE, held until next accept
DIV0  output  1  divide-by-zero flag, valid with DONE, held until next accept

Behaviour:
- Reset: at any rising CLK edge with RESET=0, the block enters IDLE and clears everything:
  - Quot=0, Rem=0, BUSY=0, DONE=0, OVF=0, DIV0=0.
  - Internal iteration counter = 0.
  - Reset overrides everything, including mid-division; no DONE is produced for an aborted operation.
- States: IDLE, LOAD, ITER, FIN.
- IDLE:
  - START=1 at edge 0 latches in_Dvd and in_Dvs, clears OVF and DIV0, and moves to LOAD.
  - Input changes after edge 0 have no effect on the operation.
- LOAD (edge 1):
  - Divisor==0: DIV0=1, go to FIN.
  - Else if Dvd[24:16] >= Dvs: OVF=1, go to FIN.
  - Else: R = Dvd[24:16] (9 bits), Q = Dvd[15:0], counter=0, go to ITER.
  - If both conditions hold, only DIV0 is set.
- ITER (edges 2..17, exactly 16 iterations):
  - T = {R, Q[15]} (10 bits); Q shifts left.
  - If T >= {0,Dvs}: R = T-Dvs and Q[0]=1.
  - Else: R = T[8:0] and Q[0]=0.
  - R < Dvs holds throughout, so 10-bit compare and subtract width suffice.
  - Counter increments; at counter==15 the state moves to FIN.
- FIN:
  - Normal completion: Quot=Q, Rem=R.
  - Error completion: outputs per Optional Feature.
  - DONE=1 for exactly this one cycle, then IDLE.
- Latency, counting from the START-accept edge to the edge that samples DONE=1:
  - Normal: 18 edges (FIN entered at edge 17).
  - Error: 2 edges (FIN entered at edge 1).
- START handling:
  - START while BUSY (LOAD/ITER/FIN) is ignored and not queued.
  - START held high continuously is accepted again at the first IDLE cycle after FIN.
- Quot, Rem, OVF and DIV0 stay stable from FIN until the next accepted START.

Optional Feature:
Macro QUOT_SAT_EN controls the outputs on error completion (OVF or DIV0).
- Defined: Quot=16'hFFFF, Rem=9'h000.
- Undefined: Quot=16'h0000, Rem=9'h000.
- Flags and timing are identical in both builds.

Test Plan:
- in_Dvd=1000, in_Dvs=7, START pulse -> DONE sampled 18 edges later; Quot=142, Rem=6, OVF=0, DIV0=0; BUSY high for the whole operation.
- in_Dvd=370200 (1234*300), in_Dvs=300 -> Quot=1234, Rem=0; extreme case in_Dvd=25'h1FEFE01, in_Dvs=9'h1FF -> Quot=16'hFFFF, Rem=0.
- in_Dvd=25'h1FFFFFF, in_Dvs=9'h1FF -> OVF=1 and DONE at edge 2; Quot=16'h0000, or 16'hFFFF with QUOT_SAT_EN; Rem=0.
- in_Dvd=100, in_Dvs=0 -> DIV0=1, OVF=0, DONE at edge 2; Quot per macro; Rem=0.
- Start 1000/7, then at ITER edge 6 drive RESET=0 for 1 cycle -> next state IDLE, all outputs 0, no DONE; new START 50/5 -> Quot=10, Rem=0.
- Start 1000/7, then change inputs to 9/3 and pulse START at edge 5 -> ignored; result still 142 r 6; START held high after FIN -> new operation accepted the following cycle.

Source files
------------

// File: rtl/seq_div25x9.sv
// seq_div25x9: sequential restoring divider, 25-bit dividend / 9-bit divisor,
// one quotient bit per clock, 16-bit quotient and 9-bit remainder.
// Optional macro QUOT_SAT_EN: on error completion (OVF or DIV0) Quot reads
// 16'hFFFF instead of 16'h0000.
module seq_div25x9 (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [24:0] in_Dvd,
    input  logic [8:0]  in_Dvs,
    output logic [15:0] Quot,
    output logic [8:0]  Rem,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVF,
    output logic        DIV0
);

    localparam int unsigned DVD_W = 25;
    localparam int unsigned DVS_W = 9;
    localparam int unsigned QUO_W = DVD_W - DVS_W;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(QUO_W - 1);

`ifdef QUOT_SAT_EN
    localparam logic [QUO_W-1:0] ERR_QUOT = '1;
`else
    localparam logic [QUO_W-1:0] ERR_QUOT = '0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [DVD_W-1:0]   dvd_q, dvd_nxt;
    logic [DVS_W-1:0]   dvs_q, dvs_nxt;
    logic [DVS_W-1:0]   r_q, r_nxt;
    logic [QUO_W-1:0]   q_q, q_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [QUO_W-1:0]   quot_nxt;
    logic [DVS_W-1:0]   rem_nxt;
    logic               busy_nxt, done_nxt, ovf_nxt, div0_nxt;

    // Partial remainder with the next dividend bit shifted in, and its trial difference.
    logic [DVS_W:0]     trial;
    logic [DVS_W:0]     diff;
    logic               ge;
    logic [QUO_W-1:0]   q_shift;
    logic [DVS_W-1:0]   r_step;

    // Restoring step: subtract when the shifted remainder covers the divisor.
    always_comb begin
        trial   = {r_q, q_q[QUO_W-1]};
        diff    = trial - {1'b0, dvs_q};
        ge      = (trial >= {1'b0, dvs_q});
        q_shift = {q_q[QUO_W-2:0], ge};
        r_step  = ge ? diff[DVS_W-1:0] : trial[DVS_W-1:0];
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        dvd_nxt   = dvd_q;
        dvs_nxt   = dvs_q;
        r_nxt     = r_q;
        q_nxt     = q_q;
        cnt_nxt   = cnt_q;
        quot_nxt  = Quot;
        rem_nxt   = Rem;
        ovf_nxt   = OVF;
        div0_nxt  = DIV0;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (START) begin
                    dvd_nxt   = in_Dvd;
                    dvs_nxt   = in_Dvs;
                    ovf_nxt   = 1'b0;
                    div0_nxt  = 1'b0;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (dvs_q == '0) begin
                    div0_nxt  = 1'b1;
                    quot_nxt  = ERR_QUOT;
                    rem_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end else if (dvd_q[DVD_W-1:QUO_W] >= dvs_q) begin
                    ovf_nxt   = 1'b1;
                    quot_nxt  = ERR_QUOT;
                    rem_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end else begin
                    r_nxt     = dvd_q[DVD_W-1:QUO_W];
                    q_nxt     = dvd_q[QUO_W-1:0];
                    cnt_nxt   = '0;
                    state_nxt = ITER;
                end
            end
            ITER: begin
                q_nxt   = q_shift;
                r_nxt   = r_step;
                cnt_nxt = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    quot_nxt  = q_shift;
                    rem_nxt   = r_step;
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
            dvd_q <= '0;
            dvs_q <= '0;
            r_q   <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            Quot  <= '0;
            Rem   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            OVF   <= 1'b0;
            DIV0  <= 1'b0;
        end else begin
            state <= state_nxt;
            dvd_q <= dvd_nxt;
            dvs_q <= dvs_nxt;
            r_q   <= r_nxt;
            q_q   <= q_nxt;
            cnt_q <= cnt_nxt;
            Quot  <= quot_nxt;
            Rem   <= rem_nxt;
            BUSY  <= busy_nxt;
            DONE  <= done_nxt;
            OVF   <= ovf_nxt;
            DIV0  <= div0_nxt;
        end
    end

endmodule

// File: tb/tb_seq_div25x9.sv
// Testbench for seq_div25x9: directed and random divisions against an
// arithmetic reference model (plain / and %), with handshake timing checks.
module tb_seq_div25x9;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [24:0] in_Dvd;
    logic [8:0]  in_Dvs;
    logic [15:0] Quot;
    logic [8:0]  Rem;
    logic        BUSY;
    logic        DONE;
    logic        OVF;
    logic        DIV0;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef QUOT_SAT_EN
    localparam logic [15:0] ERR_Q = 16'hFFFF;
`else
    localparam logic [15:0] ERR_Q = 16'h0000;
`endif

    seq_div25x9 dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .in_Dvd (in_Dvd),
        .in_Dvs (in_Dvs),
        .Quot   (Quot),
        .Rem    (Rem),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .OVF    (OVF),
        .DIV0   (DIV0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division, error when divisor is zero or quotient exceeds 16 bits.
    task automatic model(input logic [24:0] a, input logic [8:0] b,
                         output logic [15:0] q, output logic [8:0] r,
                         output logic eo, output logic ez);
        int unsigned ai, bi;
        ai = 32'(a);
        bi = 32'(b);
        ez = (bi == 0);
        eo = 1'b0;
        if (!ez) eo = ((ai / bi) > 65535);
        if (ez || eo) begin
            q = ERR_Q;
            r = 9'd0;
        end else begin
            q = 16'(ai / bi);
            r = 9'(ai % bi);
        end
    endtask

    // Waits for DONE at negedges; k = edges after the accept edge, bounded.
    task automatic wait_done(output int k);
        k = 0;
        while (k < 40) begin
            @(posedge CLK);
            k++;
            @(negedge CLK);
            if (DONE) break;
        end
    endtask

    // One operation. inj_edge: edge at which a stray 9/3 START is sampled.
    // rst_edge: edge at which RESET=0 is sampled (operation aborted). -1 disables.
    task automatic run_op(input string tag, input logic [24:0] a, input logic [8:0] b,
                          input int inj_edge, input int rst_edge);
        logic [15:0] eq;
        logic [8:0]  er;
        logic        eo, ez;
        int          k, elat;
        bit          busy_ok, done_seen;
        model(a, b, eq, er, eo, ez);
        elat = (eo || ez) ? 2 : 18;
        @(negedge CLK);
        START  = 1'b1;
        in_Dvd = a;
        in_Dvs = b;
        @(posedge CLK);
        @(negedge CLK);
        START  = 1'b0;
        in_Dvd = 25'($urandom);
        in_Dvs = 9'($urandom);
        chk({tag, "_flags_clr"}, {30'd0, OVF, DIV0}, 32'd0);
        k = 0;
        busy_ok = 1'b1;
        while (k < 40) begin
            if (!BUSY) busy_ok = 1'b0;
            START = 1'b0;
            if (k + 1 == inj_edge) begin
                START  = 1'b1;
                in_Dvd = 25'd9;
                in_Dvs = 9'd3;
            end
            if (k + 1 == rst_edge) RESET = 1'b0;
            @(posedge CLK);
            k++;
            @(negedge CLK);
            RESET = 1'b1;
            START = 1'b0;
            if (k == rst_edge) begin
                chk({tag, "_rst_quot"}, 32'(Quot), 32'd0);
                chk({tag, "_rst_rem"},  32'(Rem),  32'd0);
                chk({tag, "_rst_ctl"},  {28'd0, BUSY, DONE, OVF, DIV0}, 32'd0);
                done_seen = 1'b0;
                for (int i = 0; i < 25; i++) begin
                    @(negedge CLK);
                    if (DONE || BUSY) done_seen = 1'b1;
                end
                chk({tag, "_no_done_after_rst"}, 32'(done_seen), 32'd0);
                return;
            end
            if (DONE) break;
        end
        chk({tag, "_latency"}, 32'(k + 1), 32'(elat));
        chk({tag, "_busy"},    32'(busy_ok), 32'd1);
        chk({tag, "_quot"},    32'(Quot), 32'(eq));
        chk({tag, "_rem"},     32'(Rem),  32'(er));
        chk({tag, "_ovf"},     32'(OVF),  32'(eo));
        chk({tag, "_div0"},    32'(DIV0), 32'(ez));
        @(negedge CLK);
        chk({tag, "_done_pulse"}, {30'd0, DONE, BUSY}, 32'd0);
        chk({tag, "_hold"}, {Quot, 7'd0, Rem}, {eq, 7'd0, er});
    endtask

    initial begin
        int k;
        logic [24:0] a;
        logic [8:0]  b;
        RESET  = 1'b0;
        START  = 1'b0;
        in_Dvd = '0;
        in_Dvs = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_quot", 32'(Quot), 32'd0);
        chk("reset_rem",  32'(Rem),  32'd0);
        chk("reset_ctl",  {28'd0, BUSY, DONE, OVF, DIV0}, 32'd0);
        RESET = 1'b1;

        // Directed cases
        run_op("d1000_7",   25'd1000,     9'd7,     -1, -1);
        run_op("d370200",   25'd370200,   9'd300,   -1, -1);
        run_op("dmaxq",     25'h1FEFE01,  9'h1FF,   -1, -1);
        run_op("dovf",      25'h1FFFFFF,  9'h1FF,   -1, -1);
        run_op("ddiv0",     25'd100,      9'd0,     -1, -1);
        run_op("ddiv0_ovf", 25'h1FFFFFF,  9'd0,     -1, -1);
        run_op("dovf_edge", 25'h0070000,  9'd7,     -1, -1);
        run_op("dsmall",    25'd3,        9'd200,   -1, -1);
        run_op("dnormal2",  25'd123456,   9'd1,     -1, -1);

        // Abort with reset at edge 6, then a fresh operation
        run_op("dabort",    25'd1000,     9'd7,     -1, 6);
        run_op("d50_5",     25'd50,       9'd5,     -1, -1);

        // Stray START while busy is ignored
        run_op("dignore",   25'd1000,     9'd7,     5, -1);

        // START held high: re-accepted on the first IDLE cycle after FIN
        @(negedge CLK);
        START  = 1'b1;
        in_Dvd = 25'd1000;
        in_Dvs = 9'd7;
        @(posedge CLK);
        @(negedge CLK);
        in_Dvd = 25'd50;
        in_Dvs = 9'd5;
        wait_done(k);
        chk("held_lat1", 32'(k + 1), 32'd18);
        chk("held_q1", {Quot, 7'd0, Rem}, {16'd142, 7'd0, 9'd6});
        @(negedge CLK);
        chk("held_idle", 32'(BUSY), 32'd0);
        @(negedge CLK);
        chk("held_reaccept", 32'(BUSY), 32'd1);
        START = 1'b0;
        wait_done(k);
        chk("held_lat2", 32'(k + 1), 32'd18);
        chk("held_q2", {Quot, 7'd0, Rem}, {16'd10, 7'd0, 9'd0});
        @(negedge CLK);

        // Random operations: mix of in-range and raw (mostly overflow) dividends
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 0) begin
                b = 9'd0;
                a = 25'($urandom);
            end else if (i % 3 == 0) begin
                b = 9'($urandom_range(1, 511));
                a = 25'($urandom);
            end else begin
                int unsigned qq, rr;
                b  = 9'($urandom_range(1, 511));
                qq = $urandom_range(0, 65535);
                rr = $urandom_range(0, 32'(b) - 1);
                a  = 25'(qq * 32'(b) + rr);
            end
            run_op($sformatf("rnd%0d", i), a, b, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
